// File: rtl/vga_pkg.sv
// Shared timing defaults and derived constants for the VGA raster generator.
// The defaults describe 800x600@60 Hz at a 40 MHz pixel clock. A line or a
// frame is laid out as sync, back porch, active, then front porch.
package vga_pkg;

  localparam int DEF_CW       = 11;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  function automatic int axis_total(input int sync, input int bp,
                                    input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  localparam int H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);
  localparam int HA0     = DEF_H_SYNC + DEF_H_BP;
  localparam int VA0     = DEF_V_SYNC + DEF_V_BP;

  // Per-axis decode of the current (pre-increment) count.
  typedef struct packed {
    logic tc;      // count is at TOTAL-1
    logic sync;    // count inside the sync interval
    logic active;  // count inside the active interval
  } axis_dec_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Generic modulo counter for one raster axis.
//   clk_i, clear_n_i : clock, async active-low reset
//   en_i             : advance one step
//   cnt_o            : current count, 0 .. TOTAL-1
//   dec_o            : terminal-count / sync / active decode of cnt_o
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int CW     = 11,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter int ACTIVE = 800,
  parameter int FP     = 40
) (
  input  logic          clk_i,
  input  logic          clear_n_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output axis_dec_t     dec_o
);

  localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_E  = CW'(SYNC);
  localparam logic [CW-1:0] ACT_B   = CW'(SYNC + BP);
  localparam logic [CW-1:0] ACT_E   = CW'(SYNC + BP + ACTIVE);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    dec_o.tc     = (cnt_q == LAST);
    dec_o.sync   = (cnt_q < SYNC_E);
    dec_o.active = (cnt_q >= ACT_B) && (cnt_q < ACT_E);
    cnt_d        = dec_o.tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge clear_n_i) begin
    if (!clear_n_i)  cnt_q <= '0;
    else if (en_i)   cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a run-time positioned window.
//   clk, clear_n     : clock, async active-low reset
//   ce               : pixel clock enable
//   win_x, win_y     : window origin in active-area coordinates, sampled at
//                      frame start so a frame never tears
//   hsync, vsync     : syncs with polarity HS_POL / VS_POL
//   draw             : pixel inside both active area and window
//   pixelx, pixely   : window-relative coordinates, 0 when draw=0
//   vblank           : line outside the active lines
//   line_start,
//   frame_start      : one-clk strobes after the ce edge at hcnt=0 / (0,0)
//   frame_cnt        : completed frames, wraps
// All outputs are registered and describe the count held before each ce edge.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int WIN_W    = 800,
  parameter int WIN_H    = 600,
  parameter int FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               ce,
  input  logic [CW-1:0]      win_x,
  input  logic [CW-1:0]      win_y,
  output logic               hsync,
  output logic               vsync,
  output logic               draw,
  output logic [CW-1:0]      pixelx,
  output logic [CW-1:0]      pixely,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Window maths runs one bit wider so origin + size never wraps.
  localparam logic [CW:0] X0 = (CW+1)'(H_SYNC + H_BP);
  localparam logic [CW:0] Y0 = (CW+1)'(V_SYNC + V_BP);
  localparam logic [CW:0] WW = (CW+1)'(WIN_W);
  localparam logic [CW:0] WH = (CW+1)'(WIN_H);

  logic [CW-1:0] h_cnt, v_cnt;
  axis_dec_t     h_dec, v_dec;

  vga_axis_counter #(.CW(CW), .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP))
    u_hcnt (.clk_i(clk), .clear_n_i(clear_n), .en_i(ce),
            .cnt_o(h_cnt), .dec_o(h_dec));

  vga_axis_counter #(.CW(CW), .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP))
    u_vcnt (.clk_i(clk), .clear_n_i(clear_n), .en_i(ce & h_dec.tc),
            .cnt_o(v_cnt), .dec_o(v_dec));

  logic [CW-1:0]      sx_q, sy_q;
  logic               hsync_q, vsync_q, draw_q, vblank_q, ls_q, fs_q;
  logic [CW-1:0]      px_q, py_q;
  logic [FRAME_W-1:0] fc_q;

  logic [CW:0]   ax, ay;
  logic          in_x, in_y, draw_d, ls_d, fs_d;
  logic [CW-1:0] px_d, py_d;

  always_comb begin
    // ax/ay are garbage outside the active area; draw_d masks that.
    ax     = {1'b0, h_cnt} - X0;
    ay     = {1'b0, v_cnt} - Y0;
    in_x   = (ax >= {1'b0, sx_q}) && (ax < {1'b0, sx_q} + WW);
    in_y   = (ay >= {1'b0, sy_q}) && (ay < {1'b0, sy_q} + WH);
    draw_d = h_dec.active & v_dec.active & in_x & in_y;
    px_d   = draw_d ? ax[CW-1:0] - sx_q : '0;
    py_d   = draw_d ? ay[CW-1:0] - sy_q : '0;
    ls_d   = (h_cnt == '0);
    fs_d   = ls_d && (v_cnt == '0);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      draw_q   <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      vblank_q <= 1'b1;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      fc_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (ce) begin
        hsync_q  <= h_dec.sync ? HS_POL : ~HS_POL;
        vsync_q  <= v_dec.sync ? VS_POL : ~VS_POL;
        draw_q   <= draw_d;
        px_q     <= px_d;
        py_q     <= py_d;
        vblank_q <= ~v_dec.active;
        ls_q     <= ls_d;
        fs_q     <= fs_d;
        // (0,0) is inside sync, so draw never depends on the origin there.
        if (fs_d) begin
          sx_q <= win_x;
          sy_q <= win_y;
        end
        if (h_dec.tc && v_dec.tc) fc_q <= fc_q + 1'b1;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign draw        = draw_q;
  assign pixelx      = px_q;
  assign pixely      = py_q;
  assign vblank      = vblank_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule
